sma_check_pipe: RTL and testbench

//  Pipelined, parametrised segment-memory-access (SMA) bounds checker for the LISC load/store path.

---
 rtl/sma_check_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_sma_check_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sma_check_pipe.sv
// sma_check_pipe: two-stage bounds checker for tagged segment pointers.
// Stage 1 decodes the segment bounds and forms the signed sum; stage 2 flags
// overflow/underflow and selects the clamped (SAT) or unchanged (TRAP) address.
// Valid/ready handshake on both sides; faults are accounted on output handshake.
module sma_check_pipe #(
    parameter int unsigned WORD_WIDTH   = 64,
    parameter int unsigned BSIZE_WIDTH  = 6,
    parameter int unsigned LENGTH_WIDTH = 4,
    parameter int unsigned PTR_WIDTH    = 48,
    parameter int unsigned FCNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              access_type,
    input  logic [WORD_WIDTH-1:0]   tagged_pointer,
    input  logic [WORD_WIDTH-1:0]   increment,
    input  logic                    trap_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_WIDTH-1:0]   sma_address,
    output logic [WORD_WIDTH-1:0]   sma_pointer,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    fault_clear,
    output logic                    sticky_ovf,
    output logic                    sticky_unf,
    output logic [FCNT_WIDTH-1:0]   fault_count
);

    localparam int unsigned W     = WORD_WIDTH;
    localparam int unsigned SW    = WORD_WIDTH + 2;           // signed sum width, no wrap
    localparam int unsigned TAG_W = WORD_WIDTH - PTR_WIDTH;
    localparam int unsigned SHW   = BSIZE_WIDTH + 2;          // holds b_size + 4
    localparam logic [W-1:0]          ALL1  = '1;
    localparam logic [FCNT_WIDTH-1:0] FMAX  = '1;

    // ------------------------------------------------------------------
    // Handshake enables
    // ------------------------------------------------------------------
    logic v1;
    logic en1;
    logic en2;

    // Stage 2 can take new data when empty or being drained; stage 1 likewise.
    always_comb begin
        en2 = ~out_valid | out_ready;
        en1 = ~v1 | en2;
    end

    assign in_ready = en1 & ~rst;

    // ------------------------------------------------------------------
    // Stage 1 combinational decode
    // ------------------------------------------------------------------
    logic [BSIZE_WIDTH-1:0]  b_size_c;
    logic [LENGTH_WIDTH-1:0] l_size_c;
    logic [W-1:0]            ptr_c;
    logic [SHW-1:0]          lshift_c;
    logic [W-1:0]            lower_c;
    logic [W-1:0]            upper_c;
    logic [W-1:0]            last_c;
    logic [SW-1:0]           sum_c;

    // Segment bounds from b_size/l_size and the sign-extended sum.
    always_comb begin
        b_size_c = tagged_pointer[W-1 -: BSIZE_WIDTH];
        l_size_c = tagged_pointer[W-1-BSIZE_WIDTH -: LENGTH_WIDTH];
        ptr_c    = W'(tagged_pointer[PTR_WIDTH-1:0]);
        lshift_c = SHW'(b_size_c) + SHW'(4);
        if (lshift_c >= SHW'(W)) begin
            lower_c = '0;
        end else begin
            lower_c = ptr_c & (ALL1 << lshift_c);
        end
        upper_c = lower_c | (W'(l_size_c) << b_size_c);
        last_c  = (upper_c - W'(1)) & (ALL1 << access_type);
        sum_c   = SW'(ptr_c) + {{2{increment[W-1]}}, increment};
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [W-1:0]     p1_ptr;
    logic [W-1:0]     p1_lower;
    logic [W-1:0]     p1_last;
    logic [SW-1:0]    p1_sum;
    logic             p1_lnz;
    logic             p1_neg;
    logic             p1_zero;
    logic             p1_trap;
    logic [TAG_W-1:0] p1_tag;

    // Capture decoded request on accept; valid follows in_valid when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            p1_ptr   <= '0;
            p1_lower <= '0;
            p1_last  <= '0;
            p1_sum   <= '0;
            p1_lnz   <= 1'b0;
            p1_neg   <= 1'b0;
            p1_zero  <= 1'b0;
            p1_trap  <= 1'b0;
            p1_tag   <= '0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                p1_ptr   <= ptr_c;
                p1_lower <= lower_c;
                p1_last  <= last_c;
                p1_sum   <= sum_c;
                p1_lnz   <= (l_size_c != '0);
                p1_neg   <= increment[W-1];
                p1_zero  <= (increment == '0);
                p1_trap  <= trap_mode;
                p1_tag   <= tagged_pointer[W-1:PTR_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational check and address select
    // ------------------------------------------------------------------
    logic         unf_c;
    logic         ovf_c;
    logic [W-1:0] addr_c;

    // Zero-length segments only flag the increment direction and keep ptr.
    always_comb begin
        unf_c  = 1'b0;
        ovf_c  = 1'b0;
        addr_c = p1_ptr;
        if (!p1_lnz) begin
            unf_c  = p1_neg;
            ovf_c  = ~p1_neg & ~p1_zero;
            addr_c = p1_ptr;
        end else begin
            unf_c = $signed(p1_sum) < $signed({2'b00, p1_lower});
            ovf_c = $signed(p1_sum) > $signed({2'b00, p1_last});
            if (p1_trap) begin
                addr_c = (unf_c | ovf_c) ? p1_ptr : p1_sum[W-1:0];
            end else if (ovf_c) begin
                addr_c = p1_last;          // also wins when last < lower
            end else if (unf_c) begin
                addr_c = p1_lower;
            end else begin
                addr_c = p1_sum[W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (outputs)
    // ------------------------------------------------------------------
    // Outputs advance only when stage 2 is enabled, so they hold under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            sma_address <= '0;
            sma_pointer <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (en2) begin
            out_valid <= v1;
            if (v1) begin
                sma_address <= addr_c;
                sma_pointer <= {p1_tag, addr_c[PTR_WIDTH-1:0]};
                overflow    <= ovf_c;
                underflow   <= unf_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fault accounting
    // ------------------------------------------------------------------
    logic fault_evt;

    assign fault_evt = out_valid & out_ready & (overflow | underflow);

    // Clear first, then fold in a same-cycle fault event.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count <= '0;
            sticky_ovf  <= 1'b0;
            sticky_unf  <= 1'b0;
        end else if (fault_clear) begin
            fault_count <= fault_evt ? FCNT_WIDTH'(1) : '0;
            sticky_ovf  <= fault_evt & overflow;
            sticky_unf  <= fault_evt & underflow;
        end else begin
            if (fault_evt && (fault_count != FMAX)) begin
                fault_count <= fault_count + FCNT_WIDTH'(1);
            end
            sticky_ovf <= sticky_ovf | (fault_evt & overflow);
            sticky_unf <= sticky_unf | (fault_evt & underflow);
        end
    end

endmodule

// File: tb/tb_sma_check_pipe.sv
// tb_sma_check_pipe: directed and randomized checks of sma_check_pipe
// against a behavioural model of the bounds rules.
module tb_sma_check_pipe;

    localparam int FCW = 2;
    localparam logic [63:0] TAG = (64'd4 << 58) | (64'd3 << 54);

    typedef struct packed {
        logic        vld;
        logic        ovf;
        logic        unf;
        logic [63:0] addr;
        logic [63:0] ptr;
    } res_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, trap_mode, out_valid, out_ready;
    logic [2:0]  access_type;
    logic [63:0] tagged_pointer, increment, sma_address, sma_pointer;
    logic overflow, underflow, fault_clear, sticky_ovf, sticky_unf;
    logic [FCW-1:0] fault_count;

    int passed = 0;
    int total  = 0;
    res_t exp_q[$];
    int m_cnt = 0;
    bit m_sov = 1'b0;
    bit m_sun = 1'b0;

    always #5 clk = ~clk;

    sma_check_pipe #(.FCNT_WIDTH(FCW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .access_type(access_type), .tagged_pointer(tagged_pointer),
        .increment(increment), .trap_mode(trap_mode), .out_valid(out_valid),
        .out_ready(out_ready), .sma_address(sma_address), .sma_pointer(sma_pointer),
        .overflow(overflow), .underflow(underflow), .fault_clear(fault_clear),
        .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .fault_count(fault_count)
    );

    // Behavioural reference of one request.
    function automatic res_t ref_model(input logic [63:0] tp, input logic [63:0] inc,
                                       input int at, input bit trap);
        res_t r;
        int bs, ls;
        logic [63:0] ptr, lower, upper, last;
        logic signed [66:0] s;
        bs  = int'(tp[63:58]);
        ls  = int'(tp[57:54]);
        ptr = {16'h0, tp[47:0]};
        if (bs + 4 >= 64) lower = 64'd0;
        else lower = (ptr >> (bs + 4)) << (bs + 4);
        upper = lower | (64'(ls) << bs);
        last  = ((upper - 64'd1) >> at) << at;
        s = $signed({3'b000, ptr}) + $signed({{3{inc[63]}}, inc});
        r = '0;
        r.vld = 1'b1;
        if (ls == 0) begin
            r.unf  = inc[63];
            r.ovf  = !inc[63] && (inc != 64'd0);
            r.addr = ptr;
        end else begin
            r.unf = s < $signed({3'b000, lower});
            r.ovf = s > $signed({3'b000, last});
            if (trap) r.addr = (r.unf || r.ovf) ? ptr : s[63:0];
            else if (r.ovf) r.addr = last;
            else if (r.unf) r.addr = lower;
            else r.addr = s[63:0];
        end
        r.ptr = {tp[63:48], r.addr[47:0]};
        return r;
    endfunction

    // One clock: sample handshakes and outputs before the edge, update model.
    task automatic step(output bit acc, output bit hs, output res_t got, output res_t exp);
        #1;
        acc = (in_valid === 1'b1) && (in_ready === 1'b1);
        hs  = (out_valid === 1'b1) && (out_ready === 1'b1);
        got.vld = out_valid; got.ovf = overflow; got.unf = underflow;
        got.addr = sma_address; got.ptr = sma_pointer;
        exp = '0;
        if (rst) begin
            m_cnt = 0; m_sov = 1'b0; m_sun = 1'b0;
            exp_q.delete();
        end else begin
            if (hs && exp_q.size() > 0) exp = exp_q.pop_front();
            if (acc) exp_q.push_back(ref_model(tagged_pointer, increment, int'(access_type), trap_mode));
            if (fault_clear) begin m_cnt = 0; m_sov = 1'b0; m_sun = 1'b0; end
            if (hs && (exp.ovf || exp.unf)) begin
                if (m_cnt < (1 << FCW) - 1) m_cnt++;
                m_sov = m_sov | exp.ovf;
                m_sun = m_sun | exp.unf;
            end
        end
        @(posedge clk); #1;
    endtask

    // Send one request with out_ready high and return the consumed result.
    task automatic run_one(input logic [63:0] tp, input logic [63:0] inc,
                           input logic [2:0] at, input logic trap, output res_t got);
        bit acc, hs;
        res_t g, e;
        got = '0;
        tagged_pointer = tp; increment = inc; access_type = at; trap_mode = trap;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(acc, hs, g, e);
            if (acc) in_valid = 1'b0;
            if (hs) begin got = g; break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit acc, hs;
        res_t g, e;
        rst = 1'b1;
        @(posedge clk); #1;
        step(acc, hs, g, e);
        step(acc, hs, g, e);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
        total++; if (fault_count !== '0) $display("FAIL reset_count got=%0d exp=0", fault_count); else passed++;
        total++; if ({sticky_ovf, sticky_unf, overflow, underflow} !== 4'b0)
            $display("FAIL reset_flags got=%b exp=0000", {sticky_ovf, sticky_unf, overflow, underflow}); else passed++;
        total++; if (sma_address !== 64'd0 || sma_pointer !== 64'd0)
            $display("FAIL reset_addr got=%h/%h exp=0", sma_address, sma_pointer); else passed++;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", in_ready); else passed++;
    endtask

    task automatic test_basic();
        bit acc, hs;
        res_t g, e;
        tagged_pointer = TAG | 64'h105; increment = 64'h10; access_type = 3'd2;
        trap_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step(acc, hs, g, e);
        total++; if (acc !== 1'b1) $display("FAIL basic_accept got=%b exp=1", acc); else passed++;
        in_valid = 1'b0;
        step(acc, hs, g, e);
        total++; if (g.vld !== 1'b0) $display("FAIL basic_latency1 got=%b exp=0", g.vld); else passed++;
        step(acc, hs, g, e);
        total++; if (g.vld !== 1'b1) $display("FAIL basic_latency2 got=%b exp=1", g.vld); else passed++;
        total++; if (g.addr !== 64'h115 || g.ovf !== 1'b0 || g.unf !== 1'b0)
            $display("FAIL basic_addr got=%h o%b u%b exp=115 o0 u0", g.addr, g.ovf, g.unf); else passed++;
        total++; if (g.ptr !== (TAG | 64'h115)) $display("FAIL basic_ptr got=%h exp=%h", g.ptr, TAG | 64'h115); else passed++;
    endtask

    task automatic test_overflow();
        res_t g;
        run_one(TAG | 64'h105, 64'h40, 3'd2, 1'b0, g);
        total++; if (g.vld !== 1'b1 || g.ovf !== 1'b1 || g.unf !== 1'b0 || g.addr !== 64'h12C)
            $display("FAIL ovf_sat got=v%b o%b u%b %h exp=v1 o1 u0 12c", g.vld, g.ovf, g.unf, g.addr); else passed++;
        total++; if (g.ptr !== (TAG | 64'h12C)) $display("FAIL ovf_sat_ptr got=%h exp=%h", g.ptr, TAG | 64'h12C); else passed++;
        run_one(TAG | 64'h105, 64'h40, 3'd2, 1'b1, g);
        total++; if (g.vld !== 1'b1 || g.ovf !== 1'b1 || g.addr !== 64'h105)
            $display("FAIL ovf_trap got=v%b o%b %h exp=v1 o1 105", g.vld, g.ovf, g.addr); else passed++;
        run_one(TAG | 64'h105, 64'h27, 3'd2, 1'b0, g);
        total++; if (g.vld !== 1'b1 || g.ovf !== 1'b0 || g.addr !== 64'h12C)
            $display("FAIL ovf_edge_last got=v%b o%b %h exp=v1 o0 12c", g.vld, g.ovf, g.addr); else passed++;
        run_one(TAG | 64'h105, 64'h28, 3'd2, 1'b0, g);
        total++; if (g.vld !== 1'b1 || g.ovf !== 1'b1 || g.addr !== 64'h12C)
            $display("FAIL ovf_edge_past got=v%b o%b %h exp=v1 o1 12c", g.vld, g.ovf, g.addr); else passed++;
        // b_size + 4 >= W: lower bound is zero, segment is huge
        run_one((64'd60 << 58) | (64'd1 << 54) | 64'h105, 64'h10, 3'd2, 1'b0, g);
        total++; if (g.vld !== 1'b1 || g.ovf !== 1'b0 || g.unf !== 1'b0 || g.addr !== 64'h115)
            $display("FAIL wide_seg got=v%b o%b u%b %h exp=v1 o0 u0 115", g.vld, g.ovf, g.unf, g.addr); else passed++;
    endtask

    task automatic test_underflow();
        res_t g;
        run_one(TAG | 64'h105, -64'sd16, 3'd2, 1'b0, g);
        total++; if (g.vld !== 1'b1 || g.unf !== 1'b1 || g.ovf !== 1'b0 || g.addr !== 64'h100)
            $display("FAIL unf_sat got=v%b u%b o%b %h exp=v1 u1 o0 100", g.vld, g.unf, g.ovf, g.addr); else passed++;
        run_one(TAG | 64'h105, -64'sd5, 3'd2, 1'b0, g);
        total++; if (g.vld !== 1'b1 || g.unf !== 1'b0 || g.addr !== 64'h100)
            $display("FAIL unf_edge got=v%b u%b %h exp=v1 u0 100", g.vld, g.unf, g.addr); else passed++;
        run_one((64'd4 << 58) | 64'h105, -64'sd1, 3'd2, 1'b0, g);
        total++; if (g.vld !== 1'b1 || g.unf !== 1'b1 || g.ovf !== 1'b0 || g.addr !== 64'h105)
            $display("FAIL unf_lzero got=v%b u%b o%b %h exp=v1 u1 o0 105", g.vld, g.unf, g.ovf, g.addr); else passed++;
        // No wrap-around: 0x5 - 0x10 stays below a zero lower bound
        run_one((64'd60 << 58) | (64'd1 << 54) | 64'h5, -64'sd16, 3'd2, 1'b0, g);
        total++; if (g.vld !== 1'b1 || g.unf !== 1'b1 || g.addr !== 64'h0)
            $display("FAIL unf_nowrap got=v%b u%b %h exp=v1 u1 0", g.vld, g.unf, g.addr); else passed++;
    endtask

    task automatic test_back_to_back();
        bit acc, hs;
        res_t g, e;
        int idx, n_acc, n_out;
        logic [63:0] outs[3];
        idx = 0; n_acc = 0; n_out = 0;
        tagged_pointer = TAG | 64'h105; access_type = 3'd2; trap_mode = 1'b0;
        increment = 64'd0; in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(acc, hs, g, e);
            if (acc) begin n_acc++; idx++; increment = 64'(4 * idx); end
            if (k >= 2) begin
                total++; if (g.vld !== 1'b1 || g.addr !== 64'h105)
                    $display("FAIL stall_hold got=v%b %h exp=v1 105", g.vld, g.addr); else passed++;
            end
        end
        total++; if (n_acc !== 2) $display("FAIL stall_accepts got=%0d exp=2", n_acc); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b exp=0", in_ready); else passed++;
        out_ready = 1'b1;
        for (int k = 0; k < 12 && n_out < 3; k++) begin
            step(acc, hs, g, e);
            if (acc) begin idx++; increment = 64'(4 * idx); if (idx >= 3) in_valid = 1'b0; end
            if (hs) begin outs[n_out] = g.addr; n_out++; end
        end
        in_valid = 1'b0;
        total++; if (n_out !== 3 || outs[0] !== 64'h105 || outs[1] !== 64'h109 || outs[2] !== 64'h10D)
            $display("FAIL drain_order got=%0d:%h,%h,%h exp=3:105,109,10d", n_out, outs[0], outs[1], outs[2]); else passed++;
    endtask

    task automatic test_saturation();
        bit acc, hs;
        res_t g, e;
        int k;
        fault_clear = 1'b1; in_valid = 1'b0;
        step(acc, hs, g, e);
        fault_clear = 1'b0;
        total++; if (fault_count !== '0) $display("FAIL clear_count got=%0d exp=0", fault_count); else passed++;
        for (int i = 0; i < 4; i++) run_one(TAG | 64'h105, 64'h40, 3'd2, 1'b0, g);
        run_one(TAG | 64'h105, -64'sd16, 3'd2, 1'b0, g);
        total++; if (fault_count !== 2'd3) $display("FAIL sat_count got=%0d exp=3", fault_count); else passed++;
        total++; if ({sticky_ovf, sticky_unf} !== 2'b11)
            $display("FAIL sat_sticky got=%b exp=11", {sticky_ovf, sticky_unf}); else passed++;
        tagged_pointer = TAG | 64'h105; increment = 64'h40; in_valid = 1'b1; out_ready = 1'b1;
        step(acc, hs, g, e);
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 10) begin step(acc, hs, g, e); k++; end
        fault_clear = 1'b1;
        step(acc, hs, g, e);
        fault_clear = 1'b0;
        total++; if (fault_count !== 2'd1) $display("FAIL clear_evt_count got=%0d exp=1", fault_count); else passed++;
        total++; if ({sticky_ovf, sticky_unf} !== 2'b10)
            $display("FAIL clear_evt_sticky got=%b exp=10", {sticky_ovf, sticky_unf}); else passed++;
    endtask

    task automatic test_reset_midflight();
        bit acc, hs;
        res_t g, e;
        tagged_pointer = TAG | 64'h105; increment = 64'h40; access_type = 3'd2;
        trap_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) step(acc, hs, g, e);
        total++; if (g.vld !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL mid_full got=v%b r%b exp=v1 r0", g.vld, in_ready); else passed++;
        rst = 1'b1; in_valid = 1'b0;
        step(acc, hs, g, e);
        total++; if (out_valid !== 1'b0 || fault_count !== '0 || {sticky_ovf, sticky_unf} !== 2'b00)
            $display("FAIL mid_reset got=v%b c%0d s%b exp=v0 c0 s00", out_valid, fault_count, {sticky_ovf, sticky_unf}); else passed++;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", in_ready); else passed++;
        run_one(TAG | 64'h105, 64'h10, 3'd2, 1'b0, g);
        total++; if (g.vld !== 1'b1 || g.addr !== 64'h115 || g.ovf !== 1'b0 || g.unf !== 1'b0)
            $display("FAIL mid_after got=v%b %h o%b u%b exp=v1 115 o0 u0", g.vld, g.addr, g.ovf, g.unf); else passed++;
        total++; if (exp_q.size() !== 0) $display("FAIL mid_drop got=%0d exp=0 pending", exp_q.size()); else passed++;
    endtask

    function automatic logic [63:0] rand_tp();
        int bs, ls;
        logic [31:0] hi, lo;
        bs = ($urandom_range(0, 7) == 0) ? $urandom_range(56, 63) : $urandom_range(0, 12);
        ls = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15);
        hi = $urandom; lo = $urandom;
        return (64'(bs) << 58) | (64'(ls) << 54) | {10'd0, hi[21:0], lo};
    endfunction

    function automatic logic [63:0] rand_inc();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        case ($urandom_range(0, 3))
            0: return 64'($signed(a[11:0]));
            1: return 64'($signed(a[19:0]));
            2: return {a, b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic test_random();
        bit acc, hs, stalled;
        res_t g, e, prev;
        int k;
        exp_q.delete();
        stalled = 1'b0; prev = '0; in_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                tagged_pointer = rand_tp(); increment = rand_inc();
                access_type = 3'($urandom_range(0, 7)); trap_mode = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            fault_clear = ($urandom_range(0, 15) == 0);
            step(acc, hs, g, e);
            if (stalled) begin
                total++; if (g !== prev) $display("FAIL rnd_hold got=%h exp=%h", g.addr, prev.addr); else passed++;
            end
            if (hs) begin
                total++; if (g !== e)
                    $display("FAIL rnd_result got=v%b o%b u%b %h %h exp=v%b o%b u%b %h %h",
                             g.vld, g.ovf, g.unf, g.addr, g.ptr, e.vld, e.ovf, e.unf, e.addr, e.ptr);
                else passed++;
            end
            total++; if (fault_count !== FCW'(m_cnt) || sticky_ovf !== m_sov || sticky_unf !== m_sun)
                $display("FAIL rnd_faults got=c%0d o%b u%b exp=c%0d o%b u%b",
                         fault_count, sticky_ovf, sticky_unf, m_cnt, m_sov, m_sun);
            else passed++;
            stalled = g.vld && !out_ready;
            prev = g;
        end
        in_valid = 1'b0; out_ready = 1'b1; fault_clear = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            step(acc, hs, g, e);
            if (hs) begin
                total++; if (g !== e) $display("FAIL rnd_drain got=%h exp=%h", g.addr, e.addr); else passed++;
            end
            k++;
        end
        total++; if (exp_q.size() !== 0) $display("FAIL rnd_timeout got=%0d exp=0 pending", exp_q.size()); else passed++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fault_clear = 1'b0;
        trap_mode = 1'b0; access_type = 3'd0; tagged_pointer = 64'd0; increment = 64'd0;
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_saturation();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
